// File: rtl/dsp_share_arbiter_if.sv
// Requester / DSP bundle for dsp_share_arbiter.
//   req/lock/mul_en/div_en : per-requester control
//   a/b_flat, n/d_flat     : per-requester operands, requester i at slice i
//   gnt                    : registered one-hot grant (issue cycle)
//   mult_a/b, div_n/d      : operands muxed onto the shared multiplier / divider
//   mult_p, div_q          : results coming back from the shared units
//   p/q_valid, p/q_tag     : result strobe and owning requester index
// slave modport is the arbiter side; master is the requester/DSP side.
interface dsp_share_arbiter_if #(parameter int N_REQ = 4);
  localparam int TAG_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    req, lock, mul_en, div_en;
  logic [N_REQ*32-1:0] a_flat, b_flat;
  logic [N_REQ*48-1:0] n_flat, d_flat;
  logic [N_REQ-1:0]    gnt;
  logic [31:0]         mult_a, mult_b;
  logic [47:0]         div_n, div_d;
  logic [63:0]         mult_p;
  logic [47:0]         div_q;
  logic                p_valid, q_valid;
  logic [TAG_W-1:0]    p_tag, q_tag;

  modport slave (
    input  req, lock, mul_en, div_en, a_flat, b_flat, n_flat, d_flat, mult_p, div_q,
    output gnt, mult_a, mult_b, div_n, div_d, p_valid, p_tag, q_valid, q_tag
  );

  modport master (
    output req, lock, mul_en, div_en, a_flat, b_flat, n_flat, d_flat, mult_p, div_q,
    input  gnt, mult_a, mult_b, div_n, div_d, p_valid, p_tag, q_valid, q_tag
  );
endinterface

// File: rtl/dsp_share_arbiter.sv
// Time-shares one 32x32 multiplier and one 48/48 divider among N_REQ requesters.
// Registered round-robin grant with optional burst lock (up to MAX_LOCK grants),
// operand mux onto the shared units, and {valid,tag} pipelines that mark each
// result with its owner as it leaves the unit.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : requester controls/operands, grant, DSP operands/results,
//                  tagged result strobes (see dsp_share_arbiter_if)
//   stall_max_o  : longest req-to-gnt wait seen, saturating (stats build only)
//   issue_cnt_o  : number of non-null issues, wrapping (stats build only)
// Optional feature macro: DSP_ARB_STATS_EN adds stall_max_o / issue_cnt_o.
module dsp_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MULT_LAT = 3,
  parameter int DIV_LAT  = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic clk,
  input  logic rst,
  dsp_share_arbiter_if.slave bus
`ifdef DSP_ARB_STATS_EN
  ,
  output logic [15:0] stall_max_o,
  output logic [31:0] issue_cnt_o
`endif
);
  localparam int TAG_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK) + 1;
  localparam int P_ST  = MULT_LAT - 1;
  localparam int Q_ST  = DIV_LAT - 1;

  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             hold, found;
  logic [N_REQ-1:0] elig;

  // Grant selection. The current holder is excluded from elig unless it keeps
  // the lock, so nobody wins two cycles in a row without locking.
  always_comb begin
    hold       = (|(gnt_q & bus.lock & bus.req)) && (lock_cnt_q < CNT_W'(MAX_LOCK - 1));
    elig       = bus.req & ~(gnt_q & ~{N_REQ{hold}});
    gnt_d      = '0;
    ptr_d      = ptr_q;
    lock_cnt_d = '0;
    found      = 1'b0;
    if (hold) begin
      gnt_d      = gnt_q;
      lock_cnt_d = lock_cnt_q + 1'b1;
    end else begin
      // Two passes: indices at/above ptr first, then wrap to the low ones.
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && elig[i] && (TAG_W'(i) >= ptr_q)) begin
          found    = 1'b1;
          gnt_d[i] = 1'b1;
          ptr_d    = (i == N_REQ - 1) ? '0 : TAG_W'(i + 1);
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && elig[i]) begin
          found    = 1'b1;
          gnt_d[i] = 1'b1;
          ptr_d    = (i == N_REQ - 1) ? '0 : TAG_W'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= '0;
      ptr_q      <= '0;
      lock_cnt_q <= '0;
    end else begin
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Operand mux (AND-OR over the one-hot grant) and owner encode.
  logic [31:0]      mux_a, mux_b;
  logic [47:0]      mux_n, mux_d;
  logic [TAG_W-1:0] issue_tag;
  logic             mul_issue, div_issue;

  always_comb begin
    mux_a     = '0;
    mux_b     = '0;
    mux_n     = '0;
    mux_d     = '0;
    issue_tag = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mux_a = mux_a | ({32{gnt_q[i]}} & bus.a_flat[i*32 +: 32]);
      mux_b = mux_b | ({32{gnt_q[i]}} & bus.b_flat[i*32 +: 32]);
      mux_n = mux_n | ({48{gnt_q[i]}} & bus.n_flat[i*48 +: 48]);
      mux_d = mux_d | ({48{gnt_q[i]}} & bus.d_flat[i*48 +: 48]);
      if (gnt_q[i]) issue_tag = TAG_W'(i);
    end
  end

  assign mul_issue = |(gnt_q & bus.mul_en);
  assign div_issue = |(gnt_q & bus.div_en);

  // Result tracking: {valid,tag} walks alongside the op through each unit.
  logic [P_ST:0]    p_vld_pipe;
  logic [TAG_W-1:0] p_tag_pipe [P_ST+1];
  logic [Q_ST:0]    q_vld_pipe;
  logic [TAG_W-1:0] q_tag_pipe [Q_ST+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      p_vld_pipe <= '0;
      q_vld_pipe <= '0;
      for (int k = 0; k <= P_ST; k++) p_tag_pipe[k] <= '0;
      for (int k = 0; k <= Q_ST; k++) q_tag_pipe[k] <= '0;
    end else begin
      p_vld_pipe[0] <= mul_issue;
      p_tag_pipe[0] <= issue_tag;
      for (int k = 1; k <= P_ST; k++) begin
        p_vld_pipe[k] <= p_vld_pipe[k-1];
        p_tag_pipe[k] <= p_tag_pipe[k-1];
      end
      q_vld_pipe[0] <= div_issue;
      q_tag_pipe[0] <= issue_tag;
      for (int k = 1; k <= Q_ST; k++) begin
        q_vld_pipe[k] <= q_vld_pipe[k-1];
        q_tag_pipe[k] <= q_tag_pipe[k-1];
      end
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.mult_a  = mux_a;
  assign bus.mult_b  = mux_b;
  assign bus.div_n   = mux_n;
  assign bus.div_d   = mux_d;
  assign bus.p_valid = p_vld_pipe[P_ST];
  assign bus.p_tag   = p_tag_pipe[P_ST];
  assign bus.q_valid = q_vld_pipe[Q_ST];
  assign bus.q_tag   = q_tag_pipe[Q_ST];

`ifdef DSP_ARB_STATS_EN
  // Per-requester wait counters: count cycles of req without gnt, sampled
  // into stall_max on the grant cycle, then cleared.
  logic [15:0] wait_q [N_REQ];
  logic [15:0] stall_max_q;
  logic [31:0] issue_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) wait_q[i] <= '0;
      stall_max_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt_q[i]) begin
          if (wait_q[i] > stall_max_q) stall_max_q <= wait_q[i];
          wait_q[i] <= '0;
        end else if (!bus.req[i]) begin
          wait_q[i] <= '0;
        end else if (wait_q[i] != 16'hFFFF) begin
          wait_q[i] <= wait_q[i] + 16'd1;
        end
      end
      if (mul_issue || div_issue) issue_cnt_q <= issue_cnt_q + 32'd1;
    end
  end

  assign stall_max_o = stall_max_q;
  assign issue_cnt_o = issue_cnt_q;
`endif
endmodule

// File: tb/tb_dsp_share_arbiter.sv
// Self-checking bench for dsp_share_arbiter: behavioural shared_mult/shared_div
// pipelines, per-scenario tasks, and a scoreboard of tagged results checked as
// the arbiter strobes p_valid / q_valid.
module tb_dsp_share_arbiter;
  localparam int N  = 4;
  localparam int ML = 3;
  localparam int DL = 8;
  localparam int LK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsp_share_arbiter_if #(.N_REQ(N)) bus ();

`ifdef DSP_ARB_STATS_EN
  logic [15:0] stall_max;
  logic [31:0] issue_cnt;
`endif

  dsp_share_arbiter #(.N_REQ(N), .MULT_LAT(ML), .DIV_LAT(DL), .MAX_LOCK(LK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DSP_ARB_STATS_EN
    ,
    .stall_max_o (stall_max),
    .issue_cnt_o (issue_cnt)
`endif
  );

  // Behavioural shared units: fully pipelined, fixed latency.
  logic [63:0] mp [ML];
  logic [47:0] dq [DL];
  always @(posedge clk) begin
    mp[0] <= 64'(bus.mult_a) * 64'(bus.mult_b);
    for (int k = 1; k < ML; k++) mp[k] <= mp[k-1];
    dq[0] <= (bus.div_d == 48'd0) ? 48'd0 : bus.div_n / bus.div_d;
    for (int k = 1; k < DL; k++) dq[k] <= dq[k-1];
  end
  assign bus.mult_p = mp[ML-1];
  assign bus.div_q  = dq[DL-1];

  typedef struct packed {
    logic [1:0]  tag;
    logic [63:0] val;
  } exp_t;

  exp_t p_exp[$];
  exp_t q_exp[$];
  exp_t pe, qe;

  int errors = 0;
  int checks = 0;

  // Scoreboard: every result strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.p_valid) begin
      checks++;
      if (p_exp.size() == 0) begin
        errors++;
        $display("FAIL p_unexpected: got tag=%0d p=%0h, expected no result", bus.p_tag, bus.mult_p);
      end else begin
        pe = p_exp.pop_front();
        if (bus.p_tag !== pe.tag || bus.mult_p !== pe.val) begin
          errors++;
          $display("FAIL p_result: got tag=%0d p=%0h, expected tag=%0d p=%0h",
                   bus.p_tag, bus.mult_p, pe.tag, pe.val);
        end
      end
    end
    if (!rst && bus.q_valid) begin
      checks++;
      if (q_exp.size() == 0) begin
        errors++;
        $display("FAIL q_unexpected: got tag=%0d q=%0h, expected no result", bus.q_tag, bus.div_q);
      end else begin
        qe = q_exp.pop_front();
        if (bus.q_tag !== qe.tag || bus.div_q !== qe.val[47:0]) begin
          errors++;
          $display("FAIL q_result: got tag=%0d q=%0h, expected tag=%0d q=%0h",
                   bus.q_tag, bus.div_q, qe.tag, qe.val[47:0]);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_inputs();
    bus.req    = '0;
    bus.lock   = '0;
    bus.mul_en = '0;
    bus.div_en = '0;
    bus.a_flat = '0;
    bus.b_flat = '0;
    bus.n_flat = '0;
    bus.d_flat = '0;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [47:0] n, input logic [47:0] d);
    bus.a_flat[i*32 +: 32] = a;
    bus.b_flat[i*32 +: 32] = b;
    bus.n_flat[i*48 +: 48] = n;
    bus.d_flat[i*48 +: 48] = d;
  endtask

  task automatic check_gnt(input string name, input logic [N-1:0] exp);
    checks++;
    if (bus.gnt !== exp) begin
      errors++;
      $display("FAIL %s: gnt got %b, expected %b", name, bus.gnt, exp);
    end
  endtask

  task automatic do_reset();
    checks++;
    if (p_exp.size() != 0 || q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain: outstanding p=%0d q=%0d, expected 0 0", p_exp.size(), q_exp.size());
    end
    p_exp.delete();
    q_exp.delete();
    rst = 1'b1;
    clr_inputs();
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_inputs();
    bus.req = 4'b1111;
    set_ops(1, 32'd9, 32'd9, 48'd9, 48'd9);
    cyc(3);
    check_gnt("reset_gnt", 4'b0000);
    checks++;
    if (bus.p_valid !== 1'b0 || bus.q_valid !== 1'b0 || bus.p_tag !== 2'd0 || bus.q_tag !== 2'd0) begin
      errors++;
      $display("FAIL reset_pipes: got pv=%b qv=%b pt=%0d qt=%0d, expected 0 0 0 0",
               bus.p_valid, bus.q_valid, bus.p_tag, bus.q_tag);
    end
    checks++;
    if (bus.mult_a !== 32'd0 || bus.div_n !== 48'd0) begin
      errors++;
      $display("FAIL reset_mux: got a=%0h n=%0h, expected 0 0", bus.mult_a, bus.div_n);
    end
`ifdef DSP_ARB_STATS_EN
    checks++;
    if (stall_max !== 16'd0 || issue_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats: got stall=%0d issues=%0d, expected 0 0", stall_max, issue_cnt);
    end
`endif
    clr_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single_mul();
    do_reset();
    set_ops(2, 32'd3, 32'd5, 48'd0, 48'd0);
    bus.mul_en = 4'b0100;
    bus.req    = 4'b0100;
    p_exp.push_back('{tag: 2'd2, val: 64'd15});
    cyc(1);
    check_gnt("single_gnt", 4'b0100);
    checks++;
    if (bus.mult_a !== 32'd3 || bus.mult_b !== 32'd5) begin
      errors++;
      $display("FAIL single_mux: got a=%0d b=%0d, expected 3 5", bus.mult_a, bus.mult_b);
    end
    bus.req = '0;
    cyc(ML - 1);
    checks++;
    if (bus.p_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: p_valid got %b, expected 0", bus.p_valid);
    end
    cyc(1);
    checks++;
    if (bus.p_valid !== 1'b1 || bus.p_tag !== 2'd2) begin
      errors++;
      $display("FAIL single_lat: got pv=%b tag=%0d, expected 1 2", bus.p_valid, bus.p_tag);
    end
    check_gnt("single_release", 4'b0000);
    clr_inputs();
    cyc(2);
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check_gnt($sformatf("rr_%0d", k), seq[k]);
    end
    clr_inputs();
    cyc(2);
  endtask

  task automatic test_lock();
    logic [N-1:0] seq [6];
    seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010};
    do_reset();
    bus.req  = 4'b1010;
    bus.lock = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      check_gnt($sformatf("lock_%0d", k), seq[k]);
    end
    clr_inputs();
    cyc(2);
  endtask

  task automatic test_mul_div();
    do_reset();
    set_ops(0, 32'h0001_0000, 32'h0003_0000, 48'd100, 48'd7);
    bus.mul_en = 4'b0001;
    bus.div_en = 4'b0001;
    bus.req    = 4'b0001;
    p_exp.push_back('{tag: 2'd0, val: 64'h3_0000_0000});
    q_exp.push_back('{tag: 2'd0, val: 64'd14});
    cyc(1);
    check_gnt("md_gnt", 4'b0001);
    checks++;
    if (bus.div_n !== 48'd100 || bus.div_d !== 48'd7) begin
      errors++;
      $display("FAIL md_mux: got n=%0d d=%0d, expected 100 7", bus.div_n, bus.div_d);
    end
    bus.req = '0;
    for (int k = 1; k <= DL; k++) begin
      cyc(1);
      checks++;
      if (bus.p_valid !== (k == ML) || bus.q_valid !== (k == DL)) begin
        errors++;
        $display("FAIL md_timing_%0d: got pv=%b qv=%b, expected %b %b",
                 k, bus.p_valid, bus.q_valid, (k == ML), (k == DL));
      end
    end
    clr_inputs();
    cyc(2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [47:0] n, d;
    do_reset();
    for (int i = 0; i < N; i++) begin
      a = 32'd1000 + 32'(i * 7);
      b = 32'd3 + 32'(i);
      n = 48'd1000000 + 48'(i * 12345);
      d = 48'd10 + 48'(i);
      set_ops(i, a, b, n, d);
      p_exp.push_back('{tag: 2'(i), val: 64'(a) * 64'(b)});
      if (i % 2 == 0) q_exp.push_back('{tag: 2'(i), val: 64'(n / d)});
    end
    bus.mul_en = 4'b1111;
    bus.div_en = 4'b0101;
    bus.req    = 4'b1111;
    for (int k = 0; k < N; k++) begin
      cyc(1);
      check_gnt($sformatf("b2b_%0d", k), 4'(1 << k));
      bus.req[k] = 1'b0;
    end
    cyc(DL + 2);
    clr_inputs();
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_ops(0, 32'd11, 32'd13, 48'd500, 48'd5);
    set_ops(1, 32'd17, 32'd19, 48'd900, 48'd3);
    bus.mul_en = 4'b0011;
    bus.div_en = 4'b0011;
    bus.req    = 4'b0011;
    cyc(1);
    check_gnt("mid_gnt0", 4'b0001);
    cyc(1);
    check_gnt("mid_gnt1", 4'b0010);
    rst     = 1'b1;
    bus.req = '0;
    cyc(1);
    rst = 1'b0;
    check_gnt("mid_rst_gnt", 4'b0000);
    for (int k = 0; k <= DL + 1; k++) begin
      checks++;
      if (bus.p_valid !== 1'b0 || bus.q_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_flush_%0d: got pv=%b qv=%b, expected 0 0", k, bus.p_valid, bus.q_valid);
      end
      cyc(1);
    end
    clr_inputs();
  endtask

`ifdef DSP_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    set_ops(0, 32'd6, 32'd7, 48'd0, 48'd0);
    bus.mul_en = 4'b0001;
    bus.req    = 4'b1001;
    bus.lock   = 4'b0001;
    for (int k = 0; k < LK; k++) p_exp.push_back('{tag: 2'd0, val: 64'd42});
    cyc(LK + 1);
    check_gnt("stats_gnt3", 4'b1000);
    bus.req  = '0;
    bus.lock = '0;
    cyc(1);
    checks++;
    if (stall_max !== 16'd5) begin
      errors++;
      $display("FAIL stats_stall: got %0d, expected 5", stall_max);
    end
    checks++;
    if (issue_cnt !== 32'd4) begin
      errors++;
      $display("FAIL stats_issues: got %0d, expected 4", issue_cnt);
    end
    cyc(ML + 1);
    clr_inputs();
  endtask
`endif

  initial begin
    clr_inputs();
    test_reset();
    test_single_mul();
    test_round_robin();
    test_lock();
    test_mul_div();
    test_back_to_back();
    test_reset_midop();
`ifdef DSP_ARB_STATS_EN
    test_stats();
`endif
    cyc(DL + ML);
    checks++;
    if (p_exp.size() != 0 || q_exp.size() != 0) begin
      errors++;
      $display("FAIL final_drain: outstanding p=%0d q=%0d, expected 0 0", p_exp.size(), q_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
